if_prefetch_buffer: RTL and testbench

//  Instruction prefetch queue between the instruction ROM and the pipeline IF stage of sccomp.

---
 rtl/if_prefetch_buffer_pkg.sv | 22 ++
 rtl/if_prefetch_buffer_if.sv | 35 +++
 rtl/if_prefetch_buffer_sync_fifo.sv | 82 ++++++++
 rtl/if_prefetch_buffer.sv | 81 ++++++++
 tb/tb_if_prefetch_buffer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
//   XLEN     : architectural word / address width
//   PC_STEP  : byte distance between sequential instruction fetches
//   fetch_entry_t : one queued {pc, instr} pair
//   align_pc : clears the byte-offset bits of a fetch address
package if_prefetch_buffer_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Bus bundle between the prefetch buffer, the instruction ROM and the IF stage.
//   redirect_valid/redirect_pc : pipeline redirect request
//   imem_req/imem_addr/imem_rdata : ROM fetch port (1-cycle read latency)
//   stall_IF/out_valid/out_pc/out_instr : head-of-queue handshake to IF
//   occupancy : number of queued entries
// master = prefetch buffer side, slave = ROM/pipeline side.
interface if_prefetch_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  import if_prefetch_buffer_pkg::*;

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;
  logic             stall_IF;
  logic             out_valid;
  logic [XLEN-1:0]  out_pc;
  logic [XLEN-1:0]  out_instr;
  logic [OCC_W-1:0] occupancy;

  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, stall_IF,
    output imem_req, imem_addr, out_valid, out_pc, out_instr, occupancy
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, stall_IF,
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, occupancy
  );

endinterface

// File: rtl/if_prefetch_buffer_sync_fifo.sv
// Synchronous FIFO with a registered head entry and a flush input.
//   clk, rstn  : clock, async active-low reset
//   flush      : empties the FIFO; wins over push and pop
//   push/push_data : enqueue one entry
//   pop        : dequeue the head entry (ignored when empty)
//   head_valid/head_data : registered head of queue; data holds when empty
//   count      : number of stored entries
module if_prefetch_buffer_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic             pop_ok;
  logic [WIDTH-1:0] head_nxt;

  assign pop_ok = pop && (count != '0);

  // Next read pointer/count, and the entry that becomes head after this edge.
  // When the slot being pushed is the next head slot, forward push_data since
  // the storage write lands on the same edge.
  always_comb begin
    rd_ptr_nxt = rd_ptr + PTR_W'(pop_ok);
    count_nxt  = count + CNT_W'(push) - CNT_W'(pop_ok);
    head_nxt   = mem[rd_ptr_nxt];
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = push_data;
    end
  end

  // Storage array; contents are only meaningful under count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, count and registered head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr + PTR_W'(push);
      rd_ptr     <= rd_ptr_nxt;
      count      <= count_nxt;
      head_valid <= (count_nxt != '0);
      if (count_nxt != '0) begin
        head_data <= head_nxt;
      end
    end
  end

  push_when_full_a: assert property (@(posedge clk) disable iff (!rstn)
    !(push && !flush && (count == CNT_W'(DEPTH))));

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue between the instruction ROM and the IF stage.
// Issues sequential word fetches to a 1-cycle-latency ROM, queues up to DEPTH
// {pc, instr} pairs and presents the head to IF; a redirect flushes and
// restarts fetch at the new PC.
//   clk, rstn : clock, async active-low reset
//   bus       : if_prefetch_buffer_if master (redirect, ROM port, IF handshake,
//               occupancy)
module if_prefetch_buffer
  import if_prefetch_buffer_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rstn,
  if_prefetch_buffer_if.master   bus
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  req_pc;
  logic             inflight;
  logic [OCC_W-1:0] count;
  logic [OCC_W:0]   pending;
  logic             issue;
  logic             push;
  logic             pop;
  logic             head_valid;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;

  // Queued plus outstanding entries; a same-cycle pop is not credited, so the
  // queue can never be pushed while full.
  assign pending    = (OCC_W+1)'(count) + (OCC_W+1)'(inflight);
  assign issue      = rstn && !bus.redirect_valid && (pending < (OCC_W+1)'(DEPTH));
  assign push       = inflight && !bus.redirect_valid;
  assign pop        = head_valid && !bus.stall_IF && !bus.redirect_valid;
  assign push_entry = '{pc: req_pc, instr: bus.imem_rdata};

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc;
  assign bus.out_valid = head_valid;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign bus.occupancy = count;

  // Fetch address, outstanding-request flag and its PC.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= align_pc(bus.redirect_pc);
      inflight <= 1'b0;
    end else if (issue) begin
      fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      req_pc   <= fetch_pc;
      inflight <= 1'b1;
    end else begin
      inflight <= 1'b0;
    end
  end

  if_prefetch_buffer_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (bus.redirect_valid),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (head),
    .count      (count)
  );

endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Self-checking bench for if_prefetch_buffer: directed scenarios followed by
// randomized stall/redirect/reset traffic, checked against a queue-based model.
module tb_if_prefetch_buffer;
  import if_prefetch_buffer_pkg::*;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  if_prefetch_buffer_if #(.DEPTH(DEPTH)) bus ();

  if_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ROM: word at byte address a is 0x1000_0000 + a/4; garbage when not requested.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  logic [31:0] rom_q;
  assign bus.imem_rdata = rom_q;
  always @(posedge clk) rom_q <= bus.imem_req ? rom_word(bus.imem_addr) : $urandom;

  // Reference model
  fetch_entry_t mq[$];
  logic [31:0]  m_fetch, m_req_pc, m_last_pc, m_last_instr, m_seq_pc;
  bit           m_inflight;
  bit           prev_req;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_fetch      = RESET_PC;
    m_req_pc     = 32'h0;
    m_inflight   = 1'b0;
    m_last_pc    = 32'h0;
    m_last_instr = 32'h0;
    m_seq_pc     = RESET_PC;
    prev_req     = 1'b0;
  endtask

  // One clock cycle: starts and ends 1 time unit after a rising edge.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit stall);
    bit iss, do_pop;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.stall_IF       = stall;
    #1;
    iss    = !redir && ((mq.size() + int'(m_inflight)) < DEPTH);
    do_pop = (mq.size() > 0) && !stall && !redir;
    chk("imem_req", 32'(bus.imem_req), 32'(iss));
    if (iss) chk("imem_addr", bus.imem_addr, m_fetch);
    if (do_pop) chk("pop_seq", bus.out_pc, m_seq_pc);
    chk("occ_le_depth", 32'(bus.occupancy <= DEPTH), 32'd1);
    chk("no_push_full", 32'(prev_req && !redir && (bus.occupancy == DEPTH)), 32'd0);
    prev_req = bus.imem_req;
    @(posedge clk);
    if (redir) begin
      mq.delete();
      m_inflight = 1'b0;
      m_fetch    = rpc & ~32'h3;
      m_seq_pc   = m_fetch;
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        m_seq_pc += 32'd4;
      end
      if (m_inflight) mq.push_back('{pc: m_req_pc, instr: rom_word(m_req_pc)});
      if (iss) begin
        m_req_pc   = m_fetch;
        m_fetch   += 32'd4;
        m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
    if (mq.size() > 0) begin
      m_last_pc    = mq[0].pc;
      m_last_instr = mq[0].instr;
    end
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("out_pc", bus.out_pc, m_last_pc);
    chk("out_instr", bus.out_instr, m_last_instr);
    chk("occupancy", 32'(bus.occupancy), 32'(mq.size()));
  endtask

  // Asynchronous reset pulse; outputs must drop before any clock edge.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    rstn = 1'b1;
    m_reset();
  endtask

  initial begin
    bit seen_lost;
    logic [31:0] lost_pc;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.stall_IF       = 1'b0;
    m_reset();

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("init_valid", 32'(bus.out_valid), 32'd0);
    chk("init_pc", bus.out_pc, 32'h0);
    chk("init_instr", bus.out_instr, 32'h0);
    chk("init_occ", 32'(bus.occupancy), 32'd0);
    chk("init_req", 32'(bus.imem_req), 32'd0);
    rstn = 1'b1;
    m_reset();

    // 1: free-running fetch
    #1;
    chk("t1_first_addr", bus.imem_addr, RESET_PC);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 1'b0);

    // 2: stall from reset fills the queue, then drain in order
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
    chk("t2_full", 32'(bus.occupancy), 32'd4);
    chk("t2_hold_pc", bus.out_pc, 32'h0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0);

    // 3: redirect with three entries queued
    do_reset();
    for (int i = 0; i < 20 && bus.occupancy != 3; i++) cycle(1'b0, 32'h0, 1'b1);
    chk("t3_fill", 32'(bus.occupancy), 32'd3);
    cycle(1'b1, 32'h0000_0103, 1'b0);
    chk("t3_flush_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_flush_occ", 32'(bus.occupancy), 32'd0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("t3_valid", 32'(bus.out_valid), 32'd1);
    chk("t3_pc", bus.out_pc, 32'h0000_0100);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);

    // 4: redirect while a response is returning
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
    lost_pc = m_req_pc;
    cycle(1'b1, 32'h0000_0400, 1'b0);
    seen_lost = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (bus.out_valid && bus.out_pc == lost_pc) seen_lost = 1'b1;
    end
    chk("t4_lost_instr", 32'(seen_lost), 32'd0);

    // 5: back-to-back redirects
    cycle(1'b1, 32'h0000_0200, 1'b0);
    cycle(1'b1, 32'h0000_0300, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("t5_first_pc", bus.out_pc, 32'h0000_0300);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);

    // fetch_pc wraps at 2^32
    cycle(1'b1, 32'hFFFF_FFF9, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0);

    // 6: reset mid-stream with two entries queued
    do_reset();
    for (int i = 0; i < 20 && bus.occupancy != 2; i++) cycle(1'b0, 32'h0, 1'b1);
    chk("t6_fill", 32'(bus.occupancy), 32'd2);
    do_reset();
    #1;
    chk("t6_restart_addr", bus.imem_addr, RESET_PC);
    chk("t6_restart_req", 32'(bus.imem_req), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 24) == 0, $urandom,
              (i % 200 < 40) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
